// File: rtl/trigger_hub.sv
// trigger_hub: debounced buttons and MIDI note-on hits merged into
// per-instrument one-cycle trigger pulses with latched velocities.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en                output enable (parser/debouncers always run)
//   btn               pre-synchronised buttons -> instruments 0..BTN_COUNT-1
//   midi_byte(_valid) received MIDI byte and its one-cycle strobe
//   trig              one-cycle trigger pulse per instrument
//   velocity          latched 7-bit velocity per instrument
//   midi_key/vel      last note-on hit, with midi_msg_valid strobe
//
// Build option: define TRIGGER_HUB_OMNI_EN to accept notes on all
// 16 channels instead of MIDI_CHANNEL only.
module trigger_hub #(
  parameter int INSTRUMENT_COUNT = 10,
  parameter int BTN_COUNT = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter logic [7*INSTRUMENT_COUNT-1:0] MIDI_KEYS = {
    7'd51, 7'd49, 7'd44, 7'd42, 7'd46,
    7'd43, 7'd45, 7'd48, 7'd38, 7'd36},
  parameter int MIDI_CHANNEL = 9,
  parameter int BTN_VELOCITY = 127
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [BTN_COUNT-1:0]          btn,
  input  logic [7:0]                    midi_byte,
  input  logic                          midi_byte_valid,
  output logic [INSTRUMENT_COUNT-1:0]   trig,
  output logic [7*INSTRUMENT_COUNT-1:0] velocity,
  output logic [6:0]                    midi_key,
  output logic [6:0]                    midi_vel,
  output logic                          midi_msg_valid
);

`ifdef TRIGGER_HUB_OMNI_EN
  localparam logic OMNI = 1'b1;
`else
  localparam logic OMNI = 1'b0;
`endif

  localparam int CW =
    DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] BVEL = 7'(BTN_VELOCITY);

  typedef enum logic [1:0] {
    S_NONE,
    S_KEY,
    S_VEL
  } state_t;

  state_t state;
  logic run_on;
  logic [6:0] key_q;

  logic [CW-1:0] cnt [BTN_COUNT];
  logic [BTN_COUNT-1:0] stable;
  logic [BTN_COUNT-1:0] rise;
  logic [INSTRUMENT_COUNT-1:0] rise_ext;

  // Debounce: stable state flips on the cycle the counter would
  // reach DEBOUNCE_CYCLES; a rising flip is the button trigger.
  always_comb begin
    rise = '0;
    for (int i = 0; i < BTN_COUNT; i++)
      rise[i] = btn[i] & ~stable[i] & (cnt[i] == CMAX);
    rise_ext = '0;
    rise_ext[BTN_COUNT-1:0] = rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < BTN_COUNT; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < BTN_COUNT; i++) begin
        if (btn[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          cnt[i] <= '0;
          stable[i] <= btn[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  logic [6:0] data7;
  logic chan_ok;
  logic is_rt, is_note, is_drop, is_data;
  logic hit;
  logic [INSTRUMENT_COUNT-1:0] sel;
  logic [INSTRUMENT_COUNT-1:0] midi_trig;

  always_comb begin
    data7 = midi_byte[6:0];
    chan_ok = OMNI ||
      (midi_byte[3:0] == 4'(MIDI_CHANNEL));
    is_rt = midi_byte[7:3] == 5'b11111;
    is_note = midi_byte[7:5] == 3'b100 && chan_ok;
    is_drop = midi_byte[7] && !is_rt && !is_note;
    is_data = !midi_byte[7];
    hit = midi_byte_valid && is_data &&
      state == S_VEL && run_on && data7 != 7'd0;
    // Descending scan leaves the lowest matching index selected.
    sel = '0;
    for (int i = INSTRUMENT_COUNT - 1; i >= 0; i--)
      if (MIDI_KEYS[7*i +: 7] == key_q) begin
        sel = '0;
        sel[i] = 1'b1;
      end
    midi_trig = hit ? sel : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_NONE;
      run_on <= 1'b0;
      key_q <= '0;
      midi_key <= '0;
      midi_vel <= '0;
      midi_msg_valid <= 1'b0;
      trig <= '0;
      velocity <= '0;
    end else begin
      midi_msg_valid <= en & hit;
      trig <= en ? (midi_trig | rise_ext) : '0;
      if (hit) begin
        midi_key <= key_q;
        midi_vel <= data7;
      end
      if (en)
        for (int i = 0; i < INSTRUMENT_COUNT; i++)
          if (midi_trig[i])
            velocity[7*i +: 7] <= data7;
          else if (rise_ext[i])
            velocity[7*i +: 7] <= BVEL;
      if (midi_byte_valid) begin
        unique case (1'b1)
          is_rt: ;
          is_note: begin
            run_on <= midi_byte[4];
            state <= S_KEY;
          end
          is_drop: state <= S_NONE;
          is_data: begin
            unique case (state)
              S_KEY: begin
                key_q <= data7;
                state <= S_VEL;
              end
              S_VEL: state <= S_KEY;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trigger_hub.sv
// tb_trigger_hub: directed checks of trigger_hub with
// DEBOUNCE_CYCLES=4 and default parameters otherwise.
module tb_trigger_hub;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [3:0] btn = '0;
  logic [7:0] midi_byte = '0;
  logic midi_byte_valid = 1'b0;
  logic [N-1:0] trig;
  logic [7*N-1:0] velocity;
  logic [6:0] midi_key;
  logic [6:0] midi_vel;
  logic midi_msg_valid;

  int n_checks = 0;
  int n_fail = 0;
  logic [N-1:0] acc_trig;
  int acc_msg;

  trigger_hub #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .btn(btn),
    .midi_byte(midi_byte),
    .midi_byte_valid(midi_byte_valid),
    .trig(trig),
    .velocity(velocity),
    .midi_key(midi_key),
    .midi_vel(midi_vel),
    .midi_msg_valid(midi_msg_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] vel(input int i);
    return velocity[7*i +: 7];
  endfunction

  task automatic clear_acc();
    acc_trig = '0;
    acc_msg = 0;
  endtask

  // One-cycle strobe; returns on the negedge after the sampling
  // posedge, so outputs registered from this byte are visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    midi_byte = b;
    midi_byte_valid = 1'b1;
    @(negedge clk);
    midi_byte_valid = 1'b0;
    acc_trig |= trig;
    if (midi_msg_valid) acc_msg++;
  endtask

  task automatic test_reset();
    int pulses;
    int at;
    btn[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (trig !== '0) begin
      n_fail++;
      $display("FAIL rst_trig got %h want 0", trig);
    end
    n_checks++;
    if (velocity !== '0) begin
      n_fail++;
      $display("FAIL rst_vel got %h want 0", velocity);
    end
    n_checks++;
    if ({midi_msg_valid, midi_key, midi_vel} !== '0) begin
      n_fail++;
      $display("FAIL rst_midi got %b %0d %0d want 0",
        midi_msg_valid, midi_key, midi_vel);
    end
    rst_n = 1'b1;
    pulses = 0;
    at = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (trig[0]) begin
        pulses++;
        if (at < 0) at = c;
      end
    end
    n_checks++;
    if (pulses != 1 || at != 3) begin
      n_fail++;
      $display("FAIL rst_btn_held got %0d@%0d want 1@3",
        pulses, at);
    end
    btn[0] = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (vel(0) !== 7'd127) begin
      n_fail++;
      $display("FAIL rst_btn_vel got %0d want 127", vel(0));
    end
  endtask

  task automatic test_note_basic();
    clear_acc();
    send(8'h99);
    send(8'h26);
    n_checks++;
    if (acc_trig !== '0 || acc_msg != 0) begin
      n_fail++;
      $display("FAIL basic_early got %h/%0d want 0/0",
        acc_trig, acc_msg);
    end
    send(8'h64);
    n_checks++;
    if (trig !== 10'h002) begin
      n_fail++;
      $display("FAIL basic_trig got %h want 002", trig);
    end
    n_checks++;
    if (vel(1) !== 7'd100) begin
      n_fail++;
      $display("FAIL basic_vel got %0d want 100", vel(1));
    end
    n_checks++;
    if (midi_key !== 7'd38 || midi_vel !== 7'd100 ||
        midi_msg_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_msg got %0d/%0d/%b want 38/100/1",
        midi_key, midi_vel, midi_msg_valid);
    end
    @(negedge clk);
    n_checks++;
    if (trig !== '0 || midi_msg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pulse got %h/%b want 0/0",
        trig, midi_msg_valid);
    end
  endtask

  task automatic test_running_status();
    send(8'h99);
    send(8'h24);
    send(8'h7F);
    n_checks++;
    if (trig !== 10'h001 || vel(0) !== 7'd127) begin
      n_fail++;
      $display("FAIL run_first got %h/%0d want 001/127",
        trig, vel(0));
    end
    clear_acc();
    send(8'hF8);
    send(8'h33);
    n_checks++;
    if (acc_trig !== '0 || acc_msg != 0) begin
      n_fail++;
      $display("FAIL run_mid got %h/%0d want 0/0",
        acc_trig, acc_msg);
    end
    send(8'h10);
    n_checks++;
    if (trig !== 10'h200 || vel(9) !== 7'd16 ||
        midi_key !== 7'd51) begin
      n_fail++;
      $display("FAIL run_second got %h/%0d/%0d want 200/16/51",
        trig, vel(9), midi_key);
    end
  endtask

  task automatic test_silent_notes();
    clear_acc();
    send(8'h99);
    send(8'h2A);
    send(8'h00);
    send(8'h89);
    send(8'h2A);
    send(8'h40);
    n_checks++;
    if (acc_trig !== '0 || acc_msg != 0) begin
      n_fail++;
      $display("FAIL silent got %h/%0d want 0/0",
        acc_trig, acc_msg);
    end
    clear_acc();
    send(8'h99);
    send(8'h3C);
    send(8'h50);
    n_checks++;
    if (midi_msg_valid !== 1'b1 || midi_key !== 7'd60 ||
        midi_vel !== 7'd80) begin
      n_fail++;
      $display("FAIL unmapped_msg got %b/%0d/%0d want 1/60/80",
        midi_msg_valid, midi_key, midi_vel);
    end
    n_checks++;
    if (acc_trig !== '0) begin
      n_fail++;
      $display("FAIL unmapped_trig got %h want 0", acc_trig);
    end
  endtask

  task automatic test_debounce();
    int pulses;
    int at;
    pulses = 0;
    at = -1;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      if (c > 0 && trig[2]) begin
        pulses++;
        if (at < 0) at = c - 1;
      end
      if (c < 20)
        btn[2] = (c < 3) || (c >= 4 && c < 12);
    end
    n_checks++;
    if (pulses != 1 || at != 7) begin
      n_fail++;
      $display("FAIL debounce got %0d@%0d want 1@7", pulses, at);
    end
    n_checks++;
    if (vel(2) !== 7'd127) begin
      n_fail++;
      $display("FAIL debounce_vel got %0d want 127", vel(2));
    end
  endtask

  task automatic test_channel();
    clear_acc();
    send(8'h90);
    send(8'h24);
    send(8'h40);
`ifdef TRIGGER_HUB_OMNI_EN
    n_checks++;
    if (acc_trig !== 10'h001 || vel(0) !== 7'd64) begin
      n_fail++;
      $display("FAIL omni got %h/%0d want 001/64",
        acc_trig, vel(0));
    end
`else
    n_checks++;
    if (acc_trig !== '0 || acc_msg != 0 ||
        vel(0) !== 7'd127) begin
      n_fail++;
      $display("FAIL chan_reject got %h/%0d/%0d want 0/0/127",
        acc_trig, acc_msg, vel(0));
    end
`endif
  endtask

  task automatic test_reset_mid();
    send(8'h99);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (velocity !== '0 || midi_key !== '0) begin
      n_fail++;
      $display("FAIL async_rst got %h/%0d want 0/0",
        velocity, midi_key);
    end
    #2;
    rst_n = 1'b1;
    clear_acc();
    send(8'h24);
    send(8'h40);
    n_checks++;
    if (acc_trig !== '0 || acc_msg != 0) begin
      n_fail++;
      $display("FAIL rst_mid got %h/%0d want 0/0",
        acc_trig, acc_msg);
    end
    send(8'h99);
    send(8'h24);
    send(8'h7F);
    n_checks++;
    if (trig !== 10'h001 || vel(0) !== 7'd127) begin
      n_fail++;
      $display("FAIL rst_recover got %h/%0d want 001/127",
        trig, vel(0));
    end
  endtask

  task automatic test_enable();
    en = 1'b0;
    clear_acc();
    send(8'h99);
    send(8'h24);
    send(8'h40);
    n_checks++;
    if (acc_trig !== '0 || acc_msg != 0 ||
        vel(0) !== 7'd127) begin
      n_fail++;
      $display("FAIL en_off got %h/%0d/%0d want 0/0/127",
        acc_trig, acc_msg, vel(0));
    end
    en = 1'b1;
    send(8'h24);
    send(8'h40);
    n_checks++;
    if (trig !== 10'h001 || vel(0) !== 7'd64 ||
        midi_msg_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL en_on got %h/%0d/%b want 001/64/1",
        trig, vel(0), midi_msg_valid);
    end
  endtask

  initial begin
    test_reset();
    test_note_basic();
    test_running_status();
    test_silent_notes();
    test_debounce();
    test_channel();
    test_reset_mid();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trigger_hub.md
TRIGGER_HUB -- requirements
Module: trigger_hub

Interface
REQ-001 SHALL have parameter INSTRUMENT_COUNT, default 10: number of instrument trigger channels.
REQ-002 SHALL have parameter BTN_COUNT, default 4: debug buttons, mapped to instruments 0..BTN_COUNT-1; BTN_COUNT <= INSTRUMENT_COUNT.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 100000: consecutive stable cycles required before a button state change is accepted.
REQ-004 SHALL have parameter MIDI_KEYS [7*INSTRUMENT_COUNT-1:0], default {36,38,48,45,43,46,42,44,49,51} with entry i at bits [7i+6:7i]: note number per instrument.
REQ-005 SHALL have parameter MIDI_CHANNEL, default 9: accepted MIDI channel, 0-based.
REQ-006 SHALL have parameter BTN_VELOCITY, default 127: velocity reported for button triggers.
REQ-007 SHALL have ports: clk in 1, single clock; rst_n in 1, asynchronous active-low reset; en in 1, output enable; btn in BTN_COUNT, pre-synchronised buttons; midi_byte in 8, received byte; midi_byte_valid in 1, one-cycle byte strobe; trig out INSTRUMENT_COUNT, one-cycle trigger pulses; velocity out 7*INSTRUMENT_COUNT, latched velocity per instrument; midi_key out 7; midi_vel out 7; midi_msg_valid out 1, one-cycle note-on strobe.

Function
REQ-008 SHALL debounce each btn bit: per-bit counter cleared while the input equals the stable state, incremented while it differs; the stable state flips when the counter reaches DEBOUNCE_CYCLES.
REQ-009 SHALL pulse trig[i] one cycle after the stable state of btn[i] rises, and write BTN_VELOCITY into velocity[i] in the same cycle; a falling stable state produces no pulse.
REQ-010 SHALL parse MIDI with states NONE, KEY and VEL; a status byte 0x8n/0x9n on an accepted channel sets the running status and moves to KEY.
REQ-011 SHALL, in KEY, capture the data byte and move to VEL; in VEL, capture the data byte, complete the message, and return to KEY (running status).
REQ-012 SHALL ignore realtime bytes 0xF8-0xFF without changing state or running status.
REQ-013 SHALL move to NONE on any other status byte (0xA0-0xF7) or on a note status from a rejected channel; data bytes in NONE are discarded.
REQ-014 SHALL treat a completed note-on with velocity > 0 as a hit: midi_key, midi_vel and midi_msg_valid register one cycle after the VEL-byte strobe.
REQ-015 SHALL, for a hit, pulse trig[i] and load velocity[i] in the same cycle as midi_msg_valid, where i is the lowest index whose MIDI_KEYS entry equals the key; an unmapped key still strobes midi_msg_valid but produces no trig.
REQ-016 SHALL treat note-off messages and note-on with velocity 0 as consumed, with no strobe and no trigger.
REQ-017 SHALL, when a MIDI hit and a button rise target the same instrument in the same cycle, emit a single trig pulse and load the MIDI velocity.
REQ-018 SHALL, while en=0, keep the parser and debouncers running, force trig and midi_msg_valid to 0, and hold velocity unchanged.
REQ-019 SHALL ignore bit 7 of data bytes, since data bytes always have bit 7 = 0.

Reset
REQ-020 SHALL, on rst_n=0, asynchronously clear trig, midi_msg_valid, midi_key, midi_vel, velocity, debounce counters, stable states (to 0) and running status, with the parser state set to NONE.
REQ-021 SHALL, when reset asserts mid-message, discard the partial message; after release, the first data byte is ignored until a new status byte arrives.
REQ-022 SHALL NOT generate a trig pulse on reset release, including when btn is held high through reset; such a button fires only after DEBOUNCE_CYCLES.

Configuration
REQ-023 SHALL, with TRIGGER_HUB_OMNI_EN defined, accept note status bytes on all 16 channels and ignore MIDI_CHANNEL.
REQ-024 SHALL, without TRIGGER_HUB_OMNI_EN, accept note status bytes only on channel MIDI_CHANNEL and treat other channels per REQ-013.

Verification (DEBOUNCE_CYCLES=4, defaults otherwise)
REQ-025 SHALL cover: bytes 0x99,0x26,0x64 -> one cycle after the 0x64 strobe: trig[1]=1 for one cycle, velocity[1]=100, midi_key=38, midi_vel=100.
REQ-026 SHALL cover: running status, 0x99,0x24,0x7F,0xF8,0x33,0x10 -> trig[0] with velocity 127, then trig[9] with velocity 16; 0xF8 has no effect.
REQ-027 SHALL cover: 0x99,0x2A,0x00 and 0x89,0x2A,0x40 -> no trig and no midi_msg_valid; then 0x99,0x3C,0x50 -> midi_msg_valid=1 with key 60 and all trig bits 0.
REQ-028 SHALL cover: btn[2] high for 3 cycles, low for 1, then high for 4 cycles -> exactly one trig[2] pulse, after the fourth high cycle, with velocity[2]=127.
REQ-029 SHALL cover: 0x90,0x24,0x40 -> no trig without TRIGGER_HUB_OMNI_EN; trig[0] with velocity 64 when it is defined.
REQ-030 SHALL cover: rst_n pulsed low between 0x99 and 0x24, followed by 0x24,0x40 -> no trig; also en=0 during 0x99,0x24,0x40 -> no trig and velocity[0] unchanged.
